// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (DATA_BITS payload, run-time
// parity / stop bits / baud divisor, registered serial output).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of
// the shifter; without it a word is accepted only while the line is idle.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [DIV_W-1:0]     i_baud_div,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic                 o_uart_tx,
  output logic                 o_busy,
  output logic                 o_full
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     bit_cnt;
  logic [DIV_W-1:0]     reload_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     data_idx;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 two_stop_q;

  logic                 word_avail;
  logic [DATA_BITS-1:0] load_word;
  logic [DIV_W-1:0]     div_eff;
  logic                 bit_end;
  logic                 frame_end;
  logic                 load;

  // divisors below 2 are clamped so every bit lasts at least two clocks
  assign div_eff   = (i_baud_div < DIV_W'(2)) ? DIV_W'(2) : i_baud_div;
  assign bit_end   = (bit_cnt == '0);
  assign frame_end = bit_end && ((state == S_STOP2) || ((state == S_STOP1) && !two_stop_q));
  assign load      = word_avail && ((state == S_IDLE) || frame_end);

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [CNT_W-1:0]     fifo_cnt_next;
  logic                 full_q;
  logic                 push;
  logic                 pop;

  // a full FIFO refuses the write even when a pop happens in the same cycle
  assign push       = i_wr && !full_q;
  assign pop        = load;
  assign word_avail = (fifo_cnt != '0);
  assign load_word  = fifo_mem[rd_ptr];
  assign o_full     = full_q;

  // occupancy after this edge; simultaneous push and pop leave it unchanged
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt + 1'b1;
    end else if (pop && !push) begin
      fifo_cnt_next = fifo_cnt - 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_data;
    end
  end

  // wrap-around pointers, count and registered full flag
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt_next;
      full_q   <= (fifo_cnt_next == CNT_W'(FIFO_DEPTH));
    end
  end
`else
  // without storage the write itself starts the frame, so only idle accepts
  assign word_avail = i_wr && !o_busy;
  assign load_word  = i_data;
  assign o_full     = o_busy;
`endif

  // frame sequencer: latches per-frame settings at load, times bits, drives the line
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= S_IDLE;
      o_uart_tx  <= 1'b1;
      o_busy     <= 1'b0;
      bit_cnt    <= '0;
      reload_q   <= '0;
      shift_q    <= '0;
      data_idx   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (load) begin
      state      <= S_START;
      o_uart_tx  <= 1'b0;
      o_busy     <= 1'b1;
      bit_cnt    <= div_eff - 1'b1;
      reload_q   <= div_eff - 1'b1;
      shift_q    <= load_word;
      data_idx   <= '0;
      par_en_q   <= i_parity_en;
      par_bit_q  <= (^load_word) ^ i_parity_odd;
      two_stop_q <= i_two_stop;
    end else if (state != S_IDLE) begin
      if (!bit_end) begin
        bit_cnt <= bit_cnt - 1'b1;
      end else begin
        bit_cnt <= reload_q;
        case (state)
          S_START: begin
            state     <= S_DATA;
            o_uart_tx <= shift_q[0];
            data_idx  <= '0;
          end
          S_DATA: begin
            if (data_idx == LAST_IDX) begin
              if (par_en_q) begin
                state     <= S_PARITY;
                o_uart_tx <= par_bit_q;
              end else begin
                state     <= S_STOP1;
                o_uart_tx <= 1'b1;
              end
            end else begin
              data_idx  <= data_idx + 1'b1;
              shift_q   <= shift_q >> 1;
              o_uart_tx <= shift_q[1];
            end
          end
          S_PARITY: begin
            state     <= S_STOP1;
            o_uart_tx <= 1'b1;
          end
          S_STOP1: begin
            o_uart_tx <= 1'b1;
            if (two_stop_q) begin
              state <= S_STOP2;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
          S_STOP2: begin
            state     <= S_IDLE;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for uart_tx_param.
// A frame-level reference model expands each loaded word into its expected
// per-clock line waveform; a monitor compares line, busy and full every cycle.
// Follows the DUT build: define UART_TX_FIFO_EN for both or for neither.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_rstn = 1'b0;
  logic                 i_wr = 1'b0;
  logic [DATA_BITS-1:0] i_data = '0;
  logic [DIV_W-1:0]     i_baud_div = DIV_W'(4);
  logic                 i_parity_en = 1'b0;
  logic                 i_parity_odd = 1'b0;
  logic                 i_two_stop = 1'b0;
  logic                 o_uart_tx;
  logic                 o_busy;
  logic                 o_full;

  typedef struct packed {
    logic tx;
    logic busy;
    logic full;
  } obs_t;

  int checks = 0;
  int errors = 0;

  obs_t                 exp_q[$];
  bit                   wave[$];
  logic [DATA_BITS-1:0] model_fifo[$];
  bit                   model_busy = 1'b0;
  int                   busy_run = 0;
  int                   last_run = 0;

  uart_tx_param #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_wr        (i_wr),
    .i_data      (i_data),
    .i_baud_div  (i_baud_div),
    .i_parity_en (i_parity_en),
    .i_parity_odd(i_parity_odd),
    .i_two_stop  (i_two_stop),
    .o_uart_tx   (o_uart_tx),
    .o_busy      (o_busy),
    .o_full      (o_full)
  );

  always #5 i_clk = ~i_clk;

  // expand one word into its serial bits, each repeated for the bit period
  function automatic void appendFrame(input logic [DATA_BITS-1:0] w, input logic [DIV_W-1:0] div,
                                      input bit pe, input bit po, input bit ts);
    bit bits[$];
    int d;
    d = (div < 2) ? 2 : int'(div);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(w[i]);
    if (pe) bits.push_back((($countones(w) % 2) == 1) ^ po);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < d; k++) wave.push_back(bits[i]);
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // reference model: decides acceptance and loads, pushes the expected post-edge outputs
  always @(posedge i_clk) begin
    obs_t e;
    bit line_free;
    bit accept;
    bit do_load;
    logic [DATA_BITS-1:0] word;
    do_load = 1'b0;
    word = '0;
    if (!i_rstn) begin
      wave.delete();
      model_fifo.delete();
      e.tx = 1'b1;
      e.busy = 1'b0;
      e.full = 1'b0;
    end else begin
      line_free = (wave.size() == 0);
      if (FIFO_MODE) begin
        accept = i_wr && (model_fifo.size() < FIFO_DEPTH);
        if (line_free && model_fifo.size() > 0) begin
          do_load = 1'b1;
          word = model_fifo.pop_front();
        end
        if (accept) model_fifo.push_back(i_data);
      end else begin
        accept = i_wr && !model_busy;
        if (accept) begin
          do_load = 1'b1;
          word = i_data;
        end
      end
      if (do_load) appendFrame(word, i_baud_div, i_parity_en, i_parity_odd, i_two_stop);
      if (wave.size() > 0) begin
        e.tx = wave.pop_front();
        e.busy = 1'b1;
      end else begin
        e.tx = 1'b1;
        e.busy = 1'b0;
      end
      e.full = FIFO_MODE ? (model_fifo.size() == FIFO_DEPTH) : e.busy;
    end
    model_busy = e.busy;
    exp_q.push_back(e);
  end

  // monitor: compares the DUT outputs against the scoreboard every cycle
  always @(negedge i_clk) begin
    obs_t e;
    obs_t a;
    a.tx = o_uart_tx;
    a.busy = o_busy;
    a.full = o_full;
    if (!i_rstn) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checkOutput("reset tx/busy/full", int'(a), int'(3'b100));
    end else if (exp_q.size() == 0) begin
      checkOutput("scoreboard empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("cycle tx/busy/full", int'(a), int'(e));
    end
  end

  // records the length of each completed busy interval
  always @(negedge i_clk) begin
    if (o_busy) begin
      busy_run++;
    end else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic applyStimulus(input bit wr, input logic [DATA_BITS-1:0] data, input int div,
                               input bit pe, input bit po, input bit ts);
    @(posedge i_clk);
    #2;
    i_wr = wr;
    i_data = data;
    i_baud_div = DIV_W'(div);
    i_parity_en = pe;
    i_parity_odd = po;
    i_two_stop = ts;
  endtask

  task automatic idleCycles(input int n, input int div);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, div, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseReset();
    @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    @(posedge i_clk);
    #2;
    i_rstn = 1'b1;
  endtask

  initial begin
    $display("[TB] start, FIFO build = %0d", FIFO_MODE);
    repeat (3) @(posedge i_clk);
    #2;
    i_rstn = 1'b1;

    // 8N1, div 4, 0xA5: 40 clocks busy
    applyStimulus(1'b1, 8'hA5, 4, 1'b0, 1'b0, 1'b0);
    idleCycles(60, 4);
    checkOutput("8N1 busy length", last_run, 40);

    // 8E1 and 8O1 at div 3: 33 clocks, 8O2: 36 clocks
    applyStimulus(1'b1, 8'hA5, 3, 1'b1, 1'b0, 1'b0);
    idleCycles(50, 3);
    checkOutput("8E1 busy length", last_run, 33);
    applyStimulus(1'b1, 8'hA5, 3, 1'b1, 1'b1, 1'b0);
    idleCycles(50, 3);
    checkOutput("8O1 busy length", last_run, 33);
    applyStimulus(1'b1, 8'hA5, 3, 1'b1, 1'b1, 1'b1);
    idleCycles(50, 3);
    checkOutput("8O2 busy length", last_run, 36);

    // divisor below 2 behaves as 2, and a mid-frame divisor change is ignored
    applyStimulus(1'b1, 8'h13, 0, 1'b0, 1'b0, 1'b0);
    idleCycles(5, 10);
    idleCycles(40, 10);
    checkOutput("div clamp busy length", last_run, 20);

    // five writes in consecutive cycles at div 2
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DATA_BITS'(8'h51 + i), 2, 1'b0, 1'b0, 1'b0);
    idleCycles(120, 2);

    // reset in the middle of DATA, then a clean 0x3C frame
    applyStimulus(1'b1, 8'hFF, 4, 1'b0, 1'b0, 1'b0);
    idleCycles(15, 4);
    pulseReset();
    applyStimulus(1'b1, 8'h3C, 4, 1'b0, 1'b0, 1'b0);
    idleCycles(60, 4);
    checkOutput("post-reset busy length", last_run, 40);

    // randomized traffic with settings changing every cycle and rare resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulseReset();
      end else begin
        applyStimulus($urandom_range(0, 99) < 30, DATA_BITS'($urandom), int'($urandom_range(0, 6)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    idleCycles(400, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
